// File: rtl/rtc_pkg.sv
// Shared RTC definitions: bus addresses, field indices and the BCD range
// tables used by the optional range checker (RTC_BCD_CHECK_EN).
package rtc_pkg;
  localparam int BUS_W     = 8;
  localparam int FIELD_CNT = 9;

  localparam logic [7:0] ADDR_COM_CYT  = 8'hF0;
  localparam logic [7:0] ADDR_SEG      = 8'h21;
  localparam logic [7:0] ADDR_MIN      = 8'h22;
  localparam logic [7:0] ADDR_HORA     = 8'h23;
  localparam logic [7:0] ADDR_DIA      = 8'h24;
  localparam logic [7:0] ADDR_MES      = 8'h25;
  localparam logic [7:0] ADDR_ANIO     = 8'h26;
  localparam logic [7:0] ADDR_SEG_TIM  = 8'h41;
  localparam logic [7:0] ADDR_MIN_TIM  = 8'h42;
  localparam logic [7:0] ADDR_HORA_TIM = 8'h43;

  localparam int SEG = 0, MIN = 1, HORA = 2, DIA = 3, MES = 4, ANIO = 5,
                 SEG_TIM = 6, MIN_TIM = 7, HORA_TIM = 8;

  // Field i address sits at index i.
  localparam logic [FIELD_CNT-1:0][7:0] FIELD_ADDR = {
    ADDR_HORA_TIM, ADDR_MIN_TIM, ADDR_SEG_TIM, ADDR_ANIO, ADDR_MES,
    ADDR_DIA, ADDR_HORA, ADDR_MIN, ADDR_SEG};

  // Packed-BCD limits; with valid nibbles a plain byte compare is exact.
  localparam logic [FIELD_CNT-1:0][7:0] BCD_MAX = {
    8'h23, 8'h59, 8'h59, 8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59};
  localparam logic [FIELD_CNT-1:0][7:0] BCD_MIN = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};

  // Address selected by the (assumed one-hot) address-phase strobes.
  function automatic logic [7:0] dir_addr(input logic [FIELD_CNT:0] sel);
    logic [7:0] a;
    a = '0;
    if (sel[0]) a |= ADDR_COM_CYT;
    for (int i = 0; i < FIELD_CNT; i++)
      if (sel[i+1]) a |= FIELD_ADDR[i];
    return a;
  endfunction
endpackage

// File: rtl/rtc_bcd_check.sv
// Combinational packed-BCD range check over all nine captured fields.
// Only built when RTC_BCD_CHECK_EN is defined.
`ifdef RTC_BCD_CHECK_EN
module rtc_bcd_check
  import rtc_pkg::*;
(
  input  logic [FIELD_CNT-1:0][7:0] fields,
  output logic                      ok
);
  logic [FIELD_CNT-1:0] fld_ok;

  for (genvar i = 0; i < FIELD_CNT; i++) begin : g_fld
    assign fld_ok[i] = (fields[i][7:4] <= 4'd9) && (fields[i][3:0] <= 4'd9) &&
                       (fields[i] >= BCD_MIN[i]) && (fields[i] <= BCD_MAX[i]);
  end

  assign ok = &fld_ok;
endmodule
`endif

// File: rtl/rtc_read_bank.sv
// RTC read bank: drives register addresses onto the multiplexed bus,
// captures returned bytes into shadows and commits a full sweep atomically.
// Optional macro RTC_BCD_CHECK_EN adds a BCD range check at commit.
module rtc_read_bank
  import rtc_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int N_FIELDS = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_FIELDS:0]       dir_sel,
  input  logic [N_FIELDS-1:0]     dat_sel,
  input  logic                    reg_to_rtc,
  input  logic                    rtc_to_reg,
  inout  wire  [ADDR_W-1:0]       ad_bus,
  output logic [N_FIELDS*ADDR_W-1:0] fld_out,
  output logic                    data_valid,
  output logic                    new_data,
  output logic                    sweep_err,
  output logic                    bcd_err
);
  logic [N_FIELDS-1:0][ADDR_W-1:0] shadow, shadow_nxt;
  logic [N_FIELDS-1:0]             mask, dat_q, fall, ld;
  logic [ADDR_W-1:0]               bus_q;
  logic                            rtc_q, com_q;
  logic                            multi, com_rise, commit_evt, mask_full, fields_ok, drive;

  // Bus drive only for a single address strobe, never during a read phase.
  assign drive  = reg_to_rtc && !rtc_to_reg && (dir_sel != '0) &&
                  ((dir_sel & (dir_sel - (N_FIELDS+1)'(1))) == '0);
  assign ad_bus = drive ? dir_addr(dir_sel) : 'z;

  assign fall       = dat_q & ~dat_sel;
  assign ld         = rtc_q ? fall : '0;
  assign multi      = (dat_sel & (dat_sel - N_FIELDS'(1))) != '0;
  assign com_rise   = dir_sel[0] & ~com_q;
  assign mask_full  = &(mask | ld);
  assign commit_evt = fall[N_FIELDS-1] & ~multi;

  // Shadow next-state: a load takes the last byte seen while the strobe was high.
  for (genvar i = 0; i < N_FIELDS; i++) begin : g_shd
    assign shadow_nxt[i] = ld[i] ? bus_q : shadow[i];
  end

`ifdef RTC_BCD_CHECK_EN
  rtc_bcd_check u_bcd (
    .fields (shadow_nxt),
    .ok     (fields_ok)
  );

  // Range failure on an otherwise complete sweep.
  always_ff @(posedge clk or posedge reset)
    if (reset) bcd_err <= 1'b0;
    else       bcd_err <= commit_evt & mask_full & ~fields_ok;
`else
  assign fields_ok = 1'b1;
  assign bcd_err   = 1'b0;
`endif

  // Edge detect, capture mask, shadows and atomic commit to the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_q      <= '0;
      dat_q      <= '0;
      rtc_q      <= 1'b0;
      com_q      <= 1'b0;
      shadow     <= '0;
      mask       <= '0;
      fld_out    <= '0;
      data_valid <= 1'b0;
      new_data   <= 1'b0;
      sweep_err  <= 1'b0;
    end else begin
      bus_q     <= ad_bus;
      dat_q     <= dat_sel;
      rtc_q     <= rtc_to_reg;
      com_q     <= dir_sel[0];
      shadow    <= shadow_nxt;
      new_data  <= 1'b0;
      sweep_err <= 1'b0;
      if (multi) begin
        mask      <= '0;
        sweep_err <= 1'b1;
      end else if (commit_evt) begin
        mask <= '0;
        if (!mask_full) begin
          sweep_err <= 1'b1;
        end else if (fields_ok) begin
          fld_out    <= shadow_nxt;
          new_data   <= 1'b1;
          data_valid <= 1'b1;
        end
      end else if (com_rise) begin
        mask <= '0;
      end else begin
        mask <= mask | ld;
      end
    end
  end
endmodule
